// File: rtl/adex_pkg.sv
// +----------------------------------------------------------------------+
// | adex_pkg: shared defaults, sweep FSM states and saturation helper.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package adex_pkg;

    localparam int DEF_W       = 16;
    localparam int DEF_N       = 8;
    localparam int DEF_EL      = -1120;
    localparam int DEF_VT      = -800;
    localparam int DEF_V_PEAK  = 320;
    localparam int DEF_V_RESET = -928;
    localparam int DEF_B       = 80;
    localparam int DEF_TAU_SH  = 4;
    localparam int DEF_EXP_SH  = 8;
    localparam int DEF_A_SH    = 3;
    localparam int DEF_TAUW_SH = 6;
    localparam int DEF_I_SH    = 2;
    localparam int DEF_REF_CYC = 2;
    localparam int REF_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FIN   = 2'd2
    } state_t;

    // Clamp x to the signed range of a 'bits'-wide value.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            sat = hi;
        else if (x < lo)
            sat = lo;
        else
            sat = x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adex_update_core.sv
// +----------------------------------------------------------------------+
// | adex_update_core: combinational single-neuron AdEx Euler step.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module adex_update_core
    import adex_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int EL      = DEF_EL,
    parameter int VT      = DEF_VT,
    parameter int V_PEAK  = DEF_V_PEAK,
    parameter int V_RESET = DEF_V_RESET,
    parameter int B       = DEF_B,
    parameter int TAU_SH  = DEF_TAU_SH,
    parameter int EXP_SH  = DEF_EXP_SH,
    parameter int A_SH    = DEF_A_SH,
    parameter int TAUW_SH = DEF_TAUW_SH,
    parameter int I_SH    = DEF_I_SH,
    parameter int REF_CYC = DEF_REF_CYC
) (
    input  logic signed [W-1:0]     v,
    input  logic signed [W-1:0]     w,
    input  logic        [REF_W-1:0] ref_cnt,
    input  logic signed [W-1:0]     cur,
    output logic signed [W-1:0]     v_nxt,
    output logic signed [W-1:0]     w_nxt,
    output logic        [REF_W-1:0] ref_nxt,
    output logic                    spk
);

    localparam int XW = W + 4;
    localparam int SW = 2 * W + 2;

    logic signed [XW-1:0] w_xv, w_xw, w_xi, w_lk, w_d, w_sqs, w_ex, w_vn, w_wn;
    logic signed [SW-1:0] w_sq;
    logic signed [W-1:0]  w_vs, w_ws, w_wbs;

    always_comb begin
        w_xv  = XW'(v);
        w_xw  = XW'(w);
        w_xi  = XW'(cur) >>> I_SH;
        w_lk  = (XW'(EL) - w_xv) >>> TAU_SH;
        w_d   = w_xv - XW'(VT);
        w_sq  = SW'(w_d) * SW'(w_d);
        // Square is clamped before the shift so the W+4 sums cannot overflow.
        w_sqs = XW'(sat(64'(w_sq), XW));
        w_ex  = (w_xv > XW'(VT)) ? (w_sqs >>> EXP_SH) : XW'(0);
        w_vn  = w_xv + w_lk + w_ex - w_xw + w_xi;
        w_wn  = w_xw + ((((w_xv - XW'(EL)) >>> A_SH) - w_xw) >>> TAUW_SH);
        w_vs  = W'(sat(64'(w_vn), W));
        w_ws  = W'(sat(64'(w_wn), W));
        w_wbs = W'(sat(64'(w_ws) + 64'(B), W));

        v_nxt   = w_vs;
        w_nxt   = w_ws;
        ref_nxt = '0;
        spk     = 1'b0;
        if (ref_cnt != '0) begin
            v_nxt   = W'(V_RESET);
            ref_nxt = ref_cnt - REF_W'(1);
        end else if (w_vs >= W'(V_PEAK)) begin
            spk     = 1'b1;
            v_nxt   = W'(V_RESET);
            w_nxt   = w_wbs;
            ref_nxt = REF_W'(REF_CYC);
        end
    end

endmodule

`default_nettype wire

// File: rtl/adex_neuron_array.sv
// +----------------------------------------------------------------------+
// | adex_neuron_array: N time-multiplexed AdEx neurons, one per clock.  |
// | Optional per-channel spike counters: define ADEX_SPIKE_CNT_EN.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module adex_neuron_array
    import adex_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int N       = DEF_N,
    parameter int EL      = DEF_EL,
    parameter int VT      = DEF_VT,
    parameter int V_PEAK  = DEF_V_PEAK,
    parameter int V_RESET = DEF_V_RESET,
    parameter int B       = DEF_B,
    parameter int TAU_SH  = DEF_TAU_SH,
    parameter int EXP_SH  = DEF_EXP_SH,
    parameter int A_SH    = DEF_A_SH,
    parameter int TAUW_SH = DEF_TAUW_SH,
    parameter int I_SH    = DEF_I_SH,
    parameter int REF_CYC = DEF_REF_CYC,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [N*W-1:0]      i_cur,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [N-1:0]        spike,
    input  logic [IW-1:0]       rd_idx,
    output logic signed [W-1:0] rd_v,
    output logic signed [W-1:0] rd_w
`ifdef ADEX_SPIKE_CNT_EN
    ,
    output logic [15:0]         rd_cnt
`endif
);

    state_t               r_state, w_state_nxt;
    logic [IW-1:0]        r_idx;
    logic signed [W-1:0]  r_v [N];
    logic signed [W-1:0]  r_w [N];
    logic [REF_W-1:0]     r_ref [N];
    logic [N-1:0]         r_acc, w_commit;
    logic                 w_last;
    logic signed [W-1:0]  w_cur, w_vn, w_wn;
    logic [REF_W-1:0]     w_refn;
    logic                 w_spk;

    assign w_last = (r_idx == IW'(N - 1));
    assign w_cur  = i_cur[32'(r_idx)*W +: W];

    adex_update_core #(
        .W(W), .EL(EL), .VT(VT), .V_PEAK(V_PEAK), .V_RESET(V_RESET), .B(B),
        .TAU_SH(TAU_SH), .EXP_SH(EXP_SH), .A_SH(A_SH), .TAUW_SH(TAUW_SH),
        .I_SH(I_SH), .REF_CYC(REF_CYC)
    ) u_core (
        .v       (r_v[r_idx]),
        .w       (r_w[r_idx]),
        .ref_cnt (r_ref[r_idx]),
        .cur     (w_cur),
        .v_nxt   (w_vn),
        .w_nxt   (w_wn),
        .ref_nxt (w_refn),
        .spk     (w_spk)
    );

    // FIN is not busy, so a tick arriving with done chains straight into a new sweep.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE:  if (tick) w_state_nxt = SWEEP;
            SWEEP: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = FIN;
            end
            FIN: begin
                done        = 1'b1;
                w_state_nxt = tick ? SWEEP : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_commit        = r_acc;
        w_commit[r_idx] = w_spk;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            spike   <= '0;
            overrun <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_v[k]   <= W'(EL);
                r_w[k]   <= '0;
                r_ref[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (tick && busy)
                overrun <= 1'b1;
            if (busy) begin
                r_v[r_idx]   <= w_vn;
                r_w[r_idx]   <= w_wn;
                r_ref[r_idx] <= w_refn;
                r_acc[r_idx] <= w_spk;
                if (w_last) begin
                    r_idx <= '0;
                    spike <= w_commit;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    assign rd_v = (32'(rd_idx) < N) ? r_v[rd_idx] : '0;
    assign rd_w = (32'(rd_idx) < N) ? r_w[rd_idx] : '0;

`ifdef ADEX_SPIKE_CNT_EN
    logic [15:0] r_cnt [N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++)
                r_cnt[k] <= '0;
        end else if (busy && w_spk && (r_cnt[r_idx] != 16'hFFFF)) begin
            r_cnt[r_idx] <= r_cnt[r_idx] + 16'd1;
        end
    end

    assign rd_cnt = (32'(rd_idx) < N) ? r_cnt[rd_idx] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adex_neuron_array.sv
// +----------------------------------------------------------------------+
// | tb_adex_neuron_array: randomized bench against an integer AdEx model.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_adex_neuron_array;

    localparam int W       = 16;
    localparam int N       = 8;
    localparam int EL      = -1120;
    localparam int VT      = -800;
    localparam int V_PEAK  = 320;
    localparam int V_RESET = -928;
    localparam int B       = 80;
    localparam int REF_CYC = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                tick = 1'b0;
    logic [N*W-1:0]      i_cur = '0;
    logic                busy, done, overrun;
    logic [N-1:0]        spike;
    logic [2:0]          rd_idx = '0;
    logic signed [W-1:0] rd_v, rd_w;
`ifdef ADEX_SPIKE_CNT_EN
    logic [15:0]         rd_cnt;
`endif

    int checks = 0;
    int failures = 0;

    longint      mv [N];
    longint      mw [N];
    int          mref [N];
    logic [N-1:0] mspk;

    adex_neuron_array dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .i_cur   (i_cur),
        .busy    (busy),
        .done    (done),
        .overrun (overrun),
        .spike   (spike),
        .rd_idx  (rd_idx),
        .rd_v    (rd_v),
        .rd_w    (rd_w)
`ifdef ADEX_SPIKE_CNT_EN
        ,
        .rd_cnt  (rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic longint clampw(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = EL; mw[k] = 0; mref[k] = 0;
        end
        mspk = '0;
    endtask

    // One Euler step of every neuron, straight from the update equations.
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            longint v, w, cur, lk, sq, ex, vn, wn;
            v   = mv[k];
            w   = mw[k];
            cur = longint'($signed(i_cur[k*W +: W]));
            lk  = (EL - v) >>> 4;
            sq  = (v - VT) * (v - VT);
            if (sq > 524287) sq = 524287;
            ex  = (v > VT) ? (sq >>> 8) : 0;
            vn  = clampw(v + lk + ex - w + (cur >>> 2));
            wn  = clampw(w + ((((v - EL) >>> 3) - w) >>> 6));
            if (mref[k] > 0) begin
                mv[k] = V_RESET; mw[k] = wn; mref[k] = mref[k] - 1; mspk[k] = 1'b0;
            end else if (vn >= V_PEAK) begin
                mv[k] = V_RESET; mw[k] = clampw(wn + B); mref[k] = REF_CYC; mspk[k] = 1'b1;
            end else begin
                mv[k] = vn; mw[k] = wn; mspk[k] = 1'b0;
            end
        end
    endtask

    task automatic set_cur(input int k, input int val);
        i_cur[k*W +: W] = val[W-1:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_tick(output int lat);
        int cyc;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 40);
        lat = cyc;
        model_step();
    endtask

    task automatic read_ch(input int k, output longint v, output longint w);
        rd_idx = k[2:0];
        #1;
        v = longint'(rd_v);
        w = longint'(rd_w);
    endtask

    task automatic test_reset();
        longint v, w;
        do_reset();
        #1;
        checks++; if ({busy, done, overrun} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, overrun}); end
        checks++; if (spike !== '0) begin failures++; $display("FAIL reset_spike got=%b exp=0", spike); end
        for (int k = 0; k < N; k++) begin
            read_ch(k, v, w);
            checks++; if (v != EL) begin failures++; $display("FAIL reset_v ch=%0d got=%0d exp=%0d", k, v, EL); end
            checks++; if (w != 0) begin failures++; $display("FAIL reset_w ch=%0d got=%0d exp=0", k, w); end
        end
    endtask

    task automatic test_rest();
        int lat;
        longint v, w;
        i_cur = '0;
        for (int t = 0; t < 100; t++) begin
            run_tick(lat);
            checks++; if (lat != N + 1) begin failures++; $display("FAIL rest_latency got=%0d exp=%0d", lat, N + 1); end
        end
        checks++; if (spike !== '0) begin failures++; $display("FAIL rest_spike got=%b exp=0", spike); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rest_overrun got=%b exp=0", overrun); end
        for (int k = 0; k < N; k++) begin
            read_ch(k, v, w);
            checks++; if (v != EL || w != 0) begin failures++; $display("FAIL rest_state ch=%0d got=%0d/%0d exp=%0d/0", k, v, w, EL); end
        end
    endtask

    task automatic test_drive();
        int lat;
        longint v, w;
        i_cur = '0;
        set_cur(0, 200);
        run_tick(lat);
        read_ch(0, v, w);
        checks++; if (v != -1070) begin failures++; $display("FAIL drive_v0 got=%0d exp=-1070", v); end
        checks++; if (w != 0) begin failures++; $display("FAIL drive_w0 got=%0d exp=0", w); end
        checks++; if (v != mv[0]) begin failures++; $display("FAIL drive_model got=%0d exp=%0d", v, mv[0]); end
        read_ch(1, v, w);
        checks++; if (v != EL) begin failures++; $display("FAIL drive_v1 got=%0d exp=%0d", v, EL); end
    endtask

    task automatic test_spike();
        int lat;
        longint v, w;
        logic [3:0] pat;
        pat = 4'b1001;
        i_cur = '0;
        set_cur(3, 32767);
        for (int t = 0; t < 4; t++) begin
            run_tick(lat);
            read_ch(3, v, w);
            checks++; if (spike[3] !== pat[t]) begin failures++; $display("FAIL spike_bit tick=%0d got=%b exp=%b", t, spike[3], pat[t]); end
            checks++; if (spike !== mspk) begin failures++; $display("FAIL spike_vec tick=%0d got=%b exp=%b", t, spike, mspk); end
            checks++; if (v != V_RESET) begin failures++; $display("FAIL spike_v tick=%0d got=%0d exp=%0d", t, v, V_RESET); end
            checks++; if (w != mw[3]) begin failures++; $display("FAIL spike_w tick=%0d got=%0d exp=%0d", t, w, mw[3]); end
            if (t == 0) begin
                checks++; if (w != 80) begin failures++; $display("FAIL spike_w_first got=%0d exp=80", w); end
            end
        end
    endtask

    task automatic test_random();
        int lat;
        longint v, w;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < N; k++)
                set_cur(k, int'($urandom_range(24000)) - 6000);
            run_tick(lat);
            checks++; if (spike !== mspk) begin failures++; $display("FAIL rand_spike tick=%0d got=%b exp=%b", t, spike, mspk); end
            for (int k = 0; k < N; k++) begin
                read_ch(k, v, w);
                checks++; if (v != mv[k] || w != mw[k]) begin failures++; $display("FAIL rand_state tick=%0d ch=%0d got=%0d/%0d exp=%0d/%0d", t, k, v, w, mv[k], mw[k]); end
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        longint v, w;
        do_reset();
        i_cur = '0;
        set_cur(0, -32768);
        for (int t = 0; t < 40; t++) begin
            run_tick(lat);
            read_ch(0, v, w);
            checks++; if (v > 0) begin failures++; $display("FAIL sat_nowrap tick=%0d got=%0d exp<=0", t, v); end
        end
        checks++; if (v != -32768) begin failures++; $display("FAIL sat_v got=%0d exp=-32768", v); end
        checks++; if (w != mw[0]) begin failures++; $display("FAIL sat_w got=%0d exp=%0d", w, mw[0]); end
    endtask

    task automatic test_handshake();
        int cyc, done_at, extra, lat;
        logic busy1;
        longint v, w;
        do_reset();
        i_cur = '0;
        set_cur(5, 1000);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        cyc = 0; done_at = -1; busy1 = 1'b0;
        while (done_at < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            tick = (cyc == 4);
            if (cyc == 1) busy1 = busy;
            if (done === 1'b1) done_at = cyc;
        end
        tick = 1'b0;
        model_step();
        checks++; if (done_at != N + 1) begin failures++; $display("FAIL hs_done_cycle got=%0d exp=%0d", done_at, N + 1); end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL hs_busy_c1 got=%b exp=1", busy1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hs_busy_fin got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL hs_overrun got=%b exp=1", overrun); end
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL hs_ignored_tick got=%0d exp=0", extra); end
        run_tick(lat);
        checks++; if (lat != N + 1) begin failures++; $display("FAIL hs_second_latency got=%0d exp=%0d", lat, N + 1); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL hs_overrun_sticky got=%b exp=1", overrun); end
        read_ch(5, v, w);
        checks++; if (v != mv[5] || w != mw[5]) begin failures++; $display("FAIL hs_state got=%0d/%0d exp=%0d/%0d", v, w, mv[5], mw[5]); end
    endtask

    task automatic test_reset_mid();
        int cyc, dones;
        longint v, w;
        do_reset();
        i_cur = '0;
        set_cur(0, 200);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({busy, done, overrun} !== 3'b000) begin failures++; $display("FAIL mid_flags got=%b exp=000", {busy, done, overrun}); end
        checks++; if (spike !== '0) begin failures++; $display("FAIL mid_spike got=%b exp=0", spike); end
        read_ch(0, v, w);
        checks++; if (v != EL || w != 0) begin failures++; $display("FAIL mid_state got=%0d/%0d exp=%0d/0", v, w, EL); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        dones = 0;
        for (cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rest();
        test_drive();
        test_spike();
        test_random();
        test_saturation();
        test_handshake();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
